// File: rtl/retire_stage_pkg.sv
// Shared types for the retire stage: commit packet, free-list packet, retire FSM states.
// Sizes mirror the ROB commit width and the physical register file.
package retire_stage_pkg;
  localparam int N           = 2;
  localparam int ARCH_REG_SZ = 32;
  localparam int PRN_WIDTH   = 7;
  localparam int CNT_WIDTH   = 64;
  localparam int ARN_WIDTH   = $clog2(ARCH_REG_SZ);
  localparam int SC_WIDTH    = $clog2(N + 1);

  typedef logic [PRN_WIDTH-1:0] prn_t;
  typedef logic [ARN_WIDTH-1:0] arn_t;

  typedef struct packed {
    logic        executed;
    logic        success;
    logic        is_store;
    logic        halt;
    logic        illegal;
    prn_t        dest_prn;
    arn_t        dest_arn;
    logic [31:0] pc;
  } rob_entry_t;

  typedef struct packed {
    rob_entry_t [N-1:0] entry;
  } rob_ct_packet_t;

  typedef struct packed {
    logic [N-1:0] valid;
    prn_t [N-1:0] prn;
  } free_packet_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } retire_state_t;
endpackage

// File: rtl/retire_stage_amt_regfile.sv
// Architectural map table: N ordered write ports (higher port wins), identity on reset.
// Latency: writes visible on amt read-out the cycle after; no backpressure.
module amt_regfile
  import retire_stage_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N-1:0]            wr_en,
  input  arn_t [N-1:0]            wr_arn,
  input  prn_t [N-1:0]            wr_prn,
  output prn_t [ARCH_REG_SZ-1:0]  rd_map
);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < ARCH_REG_SZ; a++) rd_map[a] <= PRN_WIDTH'(a);
    end else begin
      // arn 0 is hardwired to zero and can never be remapped
      for (int i = 0; i < N; i++)
        if (wr_en[i] && wr_arn[i] != '0) rd_map[wr_arn[i]] <= wr_prn[i];
    end
  end

endmodule

// File: rtl/retire_stage.sv
// Retire stage: walks the ROB commit packet, updates AMT, frees superseded PRNs, halt FSM.
// Latency: AMT/counter next edge, pulse outputs registered one cycle; never backpressures the ROB.
module retire_stage
  import retire_stage_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  rob_ct_packet_t               rob_ct_packet,
  input  logic                         squash,
  output logic [N-1:0]                 free_valid,
  output prn_t [N-1:0]                 free_prn,
  output logic                         restore_valid,
  output prn_t [ARCH_REG_SZ-1:0]       amt_out,
  output logic [CNT_WIDTH-1:0]         retired_cnt,
  output logic [SC_WIDTH-1:0]          store_cnt,
  output logic [N-1:0][31:0]           retire_pc,
  output logic [N-1:0]                 retire_valid,
  output logic                         halted,
  output logic                         exception
);

  retire_state_t state, next_state;

  free_packet_t             free_q, free_d;
  logic [N-1:0]             ret_vld_d;
  logic [N-1:0][31:0]       ret_pc_d;
  logic [SC_WIDTH-1:0]      store_d;
  logic [SC_WIDTH-1:0]      ret_num;
  logic                     restore_d;
  logic                     exception_d;
  logic [N-1:0]             wr_en;
  arn_t [N-1:0]             wr_arn;
  prn_t [N-1:0]             wr_prn;
  prn_t [ARCH_REG_SZ-1:0]   map;
  logic                     stop;
  rob_entry_t               e;

  amt_regfile u_amt (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_arn (wr_arn),
    .wr_prn (wr_prn),
    .rd_map (amt_out)
  );

  always_comb begin
    next_state  = state;
    free_d      = '0;
    ret_vld_d   = '0;
    ret_pc_d    = '0;
    store_d     = '0;
    ret_num     = '0;
    exception_d = exception;
    wr_en       = '0;
    wr_arn      = '0;
    wr_prn      = '0;
    map         = amt_out;
    stop        = (state == HALTED);
    e           = '0;
    for (int i = 0; i < N; i++) begin
      e = rob_ct_packet.entry[i];
      if (!stop) begin
        if (!(e.executed && e.success)) begin
          stop = 1'b1;
        end else if (e.illegal) begin
          stop        = 1'b1;
          next_state  = HALTED;
          exception_d = 1'b1;
        end else begin
          ret_vld_d[i] = 1'b1;
          ret_pc_d[i]  = e.pc;
          ret_num      = ret_num + SC_WIDTH'(1);
          if (e.is_store) store_d = store_d + SC_WIDTH'(1);
          // map reflects earlier slots of this group, so a repeated arn frees the prior slot's PRN
          if (e.dest_arn != '0) begin
            free_d.valid[i]  = 1'b1;
            free_d.prn[i]    = map[e.dest_arn];
            map[e.dest_arn]  = e.dest_prn;
            wr_en[i]         = 1'b1;
            wr_arn[i]        = e.dest_arn;
            wr_prn[i]        = e.dest_prn;
          end
          if (e.halt) begin
            stop       = 1'b1;
            next_state = HALTED;
          end
        end
      end
    end
    restore_d = squash && (state == RUN) && (next_state == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      free_q        <= '0;
      retire_valid  <= '0;
      retire_pc     <= '0;
      store_cnt     <= '0;
      restore_valid <= 1'b0;
      exception     <= 1'b0;
      retired_cnt   <= '0;
    end else begin
      state         <= next_state;
      free_q        <= free_d;
      retire_valid  <= ret_vld_d;
      retire_pc     <= ret_pc_d;
      store_cnt     <= store_d;
      restore_valid <= restore_d;
      exception     <= exception_d;
      retired_cnt   <= retired_cnt + CNT_WIDTH'(ret_num);
    end
  end

  assign halted     = (state == HALTED);
  assign free_valid = free_q.valid;
  assign free_prn   = free_q.prn;

endmodule

// File: tb/tb_retire_stage.sv
// Directed bench for retire_stage: hand-computed AMT, free, count and halt expectations.
module tb_retire_stage;
  import retire_stage_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset;
  rob_ct_packet_t          pkt;
  logic                    squash;
  logic [N-1:0]            free_valid;
  prn_t [N-1:0]            free_prn;
  logic                    restore_valid;
  prn_t [ARCH_REG_SZ-1:0]  amt_out;
  logic [CNT_WIDTH-1:0]    retired_cnt;
  logic [SC_WIDTH-1:0]     store_cnt;
  logic [N-1:0][31:0]      retire_pc;
  logic [N-1:0]            retire_valid;
  logic                    halted;
  logic                    exception;

  int checks   = 0;
  int failures = 0;

  retire_stage dut (
    .clock         (clock),
    .reset         (reset),
    .rob_ct_packet (pkt),
    .squash        (squash),
    .free_valid    (free_valid),
    .free_prn      (free_prn),
    .restore_valid (restore_valid),
    .amt_out       (amt_out),
    .retired_cnt   (retired_cnt),
    .store_cnt     (store_cnt),
    .retire_pc     (retire_pc),
    .retire_valid  (retire_valid),
    .halted        (halted),
    .exception     (exception)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_pkt();
    pkt    = '0;
    squash = 1'b0;
  endtask

  task automatic set_slot(input int i, input int arn, input int prn, input logic st,
                          input logic hlt, input logic ill, input logic [31:0] pc);
    rob_entry_t t;
    t          = '0;
    t.executed = 1'b1;
    t.success  = 1'b1;
    t.is_store = st;
    t.halt     = hlt;
    t.illegal  = ill;
    t.dest_arn = arn_t'(arn);
    t.dest_prn = prn_t'(prn);
    t.pc       = pc;
    pkt.entry[i] = t;
  endtask

  initial begin
    int amt_bad;
    clear_pkt();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    amt_bad = 0;
    for (int a = 0; a < ARCH_REG_SZ; a++) if (amt_out[a] !== prn_t'(a)) amt_bad++;
    chk("reset_amt_identity_mismatches", 64'(amt_bad), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    chk("reset_exception", 64'(exception), 64'd0);
    chk("reset_retired_cnt", retired_cnt, 64'd0);
    chk("reset_free_valid", 64'(free_valid), 64'd0);
    chk("reset_restore", 64'(restore_valid), 64'd0);

    // two independent writes
    set_slot(0, 3, 40, 1'b0, 1'b0, 1'b0, 32'h100);
    set_slot(1, 5, 41, 1'b0, 1'b0, 1'b0, 32'h104);
    tick();
    clear_pkt();
    chk("pair_free_valid", 64'(free_valid), 64'b11);
    chk("pair_free_prn0", 64'(free_prn[0]), 64'd3);
    chk("pair_free_prn1", 64'(free_prn[1]), 64'd5);
    chk("pair_amt3", 64'(amt_out[3]), 64'd40);
    chk("pair_amt5", 64'(amt_out[5]), 64'd41);
    chk("pair_retired_cnt", retired_cnt, 64'd2);
    chk("pair_retire_valid", 64'(retire_valid), 64'b11);
    chk("pair_retire_pc1", 64'(retire_pc[1]), 64'h104);
    tick();
    chk("idle_free_valid", 64'(free_valid), 64'd0);
    chk("idle_retire_valid", 64'(retire_valid), 64'd0);

    // same arn twice in one group
    set_slot(0, 7, 50, 1'b0, 1'b0, 1'b0, 32'h108);
    set_slot(1, 7, 51, 1'b0, 1'b0, 1'b0, 32'h10c);
    tick();
    clear_pkt();
    chk("fwd_free_prn0", 64'(free_prn[0]), 64'd7);
    chk("fwd_free_prn1", 64'(free_prn[1]), 64'd50);
    chk("fwd_amt7", 64'(amt_out[7]), 64'd51);
    chk("fwd_retired_cnt", retired_cnt, 64'd4);

    // arn 0 store, slot1 invalid
    set_slot(0, 0, 60, 1'b1, 1'b0, 1'b0, 32'h110);
    tick();
    clear_pkt();
    chk("zero_free_valid", 64'(free_valid), 64'd0);
    chk("zero_amt0", 64'(amt_out[0]), 64'd0);
    chk("zero_store_cnt", 64'(store_cnt), 64'd1);
    chk("zero_retired_cnt", retired_cnt, 64'd5);
    chk("zero_retire_valid", 64'(retire_valid), 64'b01);

    // gap at slot0 blocks slot1
    set_slot(1, 9, 61, 1'b1, 1'b0, 1'b0, 32'h114);
    tick();
    clear_pkt();
    chk("gap_retire_valid", 64'(retire_valid), 64'd0);
    chk("gap_amt9", 64'(amt_out[9]), 64'd9);
    chk("gap_retired_cnt", retired_cnt, 64'd5);

    // squash with retirement
    set_slot(0, 4, 33, 1'b0, 1'b0, 1'b0, 32'h118);
    squash = 1'b1;
    tick();
    clear_pkt();
    chk("sq_restore", 64'(restore_valid), 64'd1);
    chk("sq_amt4", 64'(amt_out[4]), 64'd33);
    chk("sq_retired_cnt", retired_cnt, 64'd6);
    tick();
    chk("sq_restore_pulse_end", 64'(restore_valid), 64'd0);

    // halt in slot0 with squash: halt wins, slot1 ignored
    set_slot(0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h11c);
    set_slot(1, 2, 70, 1'b0, 1'b0, 1'b0, 32'h120);
    squash = 1'b1;
    tick();
    clear_pkt();
    chk("halt_retire_valid", 64'(retire_valid), 64'b01);
    chk("halt_amt2", 64'(amt_out[2]), 64'd2);
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_exception", 64'(exception), 64'd0);
    chk("halt_restore", 64'(restore_valid), 64'd0);
    chk("halt_retired_cnt", retired_cnt, 64'd7);

    // halted: everything ignored
    set_slot(0, 6, 90, 1'b1, 1'b0, 1'b0, 32'h124);
    squash = 1'b1;
    tick();
    clear_pkt();
    chk("hold_free_valid", 64'(free_valid), 64'd0);
    chk("hold_retire_valid", 64'(retire_valid), 64'd0);
    chk("hold_restore", 64'(restore_valid), 64'd0);
    chk("hold_store_cnt", 64'(store_cnt), 64'd0);
    chk("hold_amt6", 64'(amt_out[6]), 64'd6);
    chk("hold_retired_cnt", retired_cnt, 64'd7);
    chk("hold_halted", 64'(halted), 64'd1);

    // reset mid-operation, then illegal in slot0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_amt3", 64'(amt_out[3]), 64'd3);
    chk("rst2_halted", 64'(halted), 64'd0);
    chk("rst2_retired_cnt", retired_cnt, 64'd0);
    set_slot(0, 8, 20, 1'b0, 1'b0, 1'b1, 32'h200);
    set_slot(1, 10, 21, 1'b0, 1'b0, 1'b0, 32'h204);
    squash = 1'b1;
    tick();
    clear_pkt();
    chk("ill_exception", 64'(exception), 64'd1);
    chk("ill_halted", 64'(halted), 64'd1);
    chk("ill_retired_cnt", retired_cnt, 64'd0);
    chk("ill_retire_valid", 64'(retire_valid), 64'd0);
    chk("ill_amt8", 64'(amt_out[8]), 64'd8);
    chk("ill_amt10", 64'(amt_out[10]), 64'd10);
    chk("ill_restore", 64'(restore_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
